// File: rtl/n64_pif_ram_pkg.sv
// Shared types and address helpers for the mixed-width PIF RAM.
package n64_pif_ram_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Lane (byte within wide word) addressed by a byte address.
    function automatic int unsigned lane_of(input int unsigned addr, input int unsigned lanes);
        return addr % lanes;
    endfunction

    // Wide word containing a byte address.
    function automatic int unsigned word_of(input int unsigned addr, input int unsigned lanes);
        return addr / lanes;
    endfunction

endpackage

// File: rtl/n64_pif_ram_bank.sv
// One byte lane: WORDS x 8 dual-port storage, read-before-write, port B wins a same-address write.
module n64_pif_ram_bank
    import n64_pif_ram_pkg::*;
#(
    parameter int unsigned WORDS = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     addr_a_i,
    input  logic              we_a_i,
    input  logic [BYTE_W-1:0] d_a_i,
    output logic [BYTE_W-1:0] q_a_o,
    input  logic [AW-1:0]     addr_b_i,
    input  logic              we_b_i,
    input  logic [BYTE_W-1:0] d_b_i,
    output logic [BYTE_W-1:0] q_b_o
);

    logic [BYTE_W-1:0] mem_q [WORDS];
    logic [BYTE_W-1:0] q_a_q;
    logic [BYTE_W-1:0] q_b_q;

    // Storage writes; the later port B assignment takes priority on a shared address.
    always_ff @(posedge clk) begin
        if (we_a_i) mem_q[addr_a_i] <= d_a_i;
        if (we_b_i) mem_q[addr_b_i] <= d_b_i;
    end

    // Read registers see the pre-write contents; held while the sweep runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else if (rd_en_i) begin
            q_a_q <= mem_q[addr_a_i];
            q_b_q <= mem_q[addr_b_i];
        end
    end

    assign q_a_o = q_a_q;
    assign q_b_o = q_b_q;

endmodule

// File: rtl/n64_pif_ram_mw.sv
// Mixed-width PIF RAM: byte port A, word port B with byte enables, dirty/cmd tracking, clear sweep.
module n64_pif_ram_mw
    import n64_pif_ram_pkg::*;
#(
    parameter int unsigned WORDS = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned AW_A  = $clog2(WORDS * LANES),
    parameter int unsigned AW_B  = $clog2(WORDS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [AW_A-1:0]           address_a,
    input  logic                      wren_a,
    input  logic [BYTE_W-1:0]         data_a,
    input  logic                      oe_a,
    output logic [BYTE_W-1:0]         q_a,
    output logic                      valid_a,
    input  logic [AW_B-1:0]           address_b,
    input  logic                      wren_b,
    input  logic [LANES-1:0]          be_b,
    input  logic [BYTE_W*LANES-1:0]   data_b,
    input  logic                      rd_b,
    output logic [BYTE_W*LANES-1:0]   q_b,
    output logic                      valid_b,
    output logic [WORDS-1:0]          dirty,
    output logic                      cmd_pending,
    input  logic                      cmd_ack,
    output logic                      coll,
    output logic                      busy
);

    localparam int unsigned LSW       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [AW_A-1:0] CMD_ADDR  = AW_A'(WORDS * LANES - 1);
    localparam logic [AW_B-1:0] LAST_WORD = AW_B'(WORDS - 1);

    state_e            state_q, state_d;
    logic [AW_B-1:0]   cnt_q, cnt_d;
    logic              sweep_c;
    logic              run_c;

    logic              wr_a_c, wr_b_c, rd_b_c, ack_c;
    logic [AW_B-1:0]   word_a_c;
    logic [LSW-1:0]    lane_a_c;
    logic [LSW-1:0]    lane_q;
    logic              coll_c;
    logic              cmd_d, cmd_q;
    logic [WORDS-1:0]  dirty_d, dirty_q;
    logic              valid_a_q, valid_b_q, coll_q;

    logic [AW_B-1:0]   addr_b_c;
    logic [BYTE_W-1:0] qa_lane [LANES];

    // Sweep state and word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep next state: advance one word per cycle, leave after the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AW_B'(1);
                if (cnt_q == LAST_WORD) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // Sweep outputs: storage is owned by the clear while in CLEAR.
    always_comb begin
        sweep_c = 1'b0;
        case (state_q)
            CLEAR:   sweep_c = 1'b1;
            default: sweep_c = 1'b0;
        endcase
    end

    assign run_c = ~sweep_c;
    assign busy  = sweep_c;

    // Accepted port requests and port A address split.
    always_comb begin
        wr_a_c   = wren_a & run_c;
        wr_b_c   = wren_b & run_c;
        rd_b_c   = rd_b & run_c;
        ack_c    = cmd_ack & run_c;
        word_a_c = AW_B'(word_of(32'(address_a), LANES));
        lane_a_c = LSW'(lane_of(32'(address_a), LANES));
        coll_c   = wr_a_c & wr_b_c & be_b[lane_a_c] & (word_a_c == address_b);
    end

    // Dirty and command flags: set by port A writes, set beats clear.
    always_comb begin
        dirty_d = dirty_q;
        cmd_d   = cmd_q;
        if (rd_b_c) dirty_d[address_b] = 1'b0;
        if (wr_a_c) dirty_d[word_a_c]  = 1'b1;
        if (ack_c)  cmd_d = 1'b0;
        if (wr_a_c && (address_a == CMD_ADDR)) cmd_d = 1'b1;
    end

    // Status registers and the port A lane select for the read mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            coll_q    <= 1'b0;
            cmd_q     <= 1'b0;
            dirty_q   <= '0;
            lane_q    <= '0;
        end else begin
            valid_a_q <= oe_a & run_c;
            valid_b_q <= rd_b & run_c;
            coll_q    <= coll_c;
            cmd_q     <= cmd_d;
            dirty_q   <= dirty_d;
            if (run_c) lane_q <= lane_a_c;
        end
    end

    assign addr_b_c = sweep_c ? cnt_q : address_b;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic              we_a_l;
        logic              we_b_l;
        logic [BYTE_W-1:0] d_b_l;

        assign we_a_l = wr_a_c & (lane_a_c == LSW'(i));
        assign we_b_l = sweep_c | (wr_b_c & be_b[i]);
        assign d_b_l  = sweep_c ? '0 : data_b[BYTE_W*i +: BYTE_W];

        n64_pif_ram_bank #(
            .WORDS (WORDS),
            .AW    (AW_B)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .rd_en_i  (run_c),
            .addr_a_i (word_a_c),
            .we_a_i   (we_a_l),
            .d_a_i    (data_a),
            .q_a_o    (qa_lane[i]),
            .addr_b_i (addr_b_c),
            .we_b_i   (we_b_l),
            .d_b_i    (d_b_l),
            .q_b_o    (q_b[BYTE_W*i +: BYTE_W])
        );
    end

    assign q_a         = qa_lane[lane_q];
    assign valid_a     = valid_a_q;
    assign valid_b     = valid_b_q;
    assign coll        = coll_q;
    assign cmd_pending = cmd_q;
    assign dirty       = dirty_q;

endmodule

// File: tb/tb_n64_pif_ram_mw.sv
// Bench for n64_pif_ram_mw: directed scenarios plus random traffic against a byte-array model.
module tb_n64_pif_ram_mw;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  address_a;
    logic        wren_a;
    logic [7:0]  data_a;
    logic        oe_a;
    logic [7:0]  q_a;
    logic        valid_a;
    logic [3:0]  address_b;
    logic        wren_b;
    logic [3:0]  be_b;
    logic [31:0] data_b;
    logic        rd_b;
    logic [31:0] q_b;
    logic        valid_b;
    logic [15:0] dirty;
    logic        cmd_pending;
    logic        cmd_ack;
    logic        coll;
    logic        busy;

    n64_pif_ram_mw dut (
        .clk         (clk),
        .reset       (reset),
        .address_a   (address_a),
        .wren_a      (wren_a),
        .data_a      (data_a),
        .oe_a        (oe_a),
        .q_a         (q_a),
        .valid_a     (valid_a),
        .address_b   (address_b),
        .wren_b      (wren_b),
        .be_b        (be_b),
        .data_b      (data_b),
        .rd_b        (rd_b),
        .q_b         (q_b),
        .valid_b     (valid_b),
        .dirty       (dirty),
        .cmd_pending (cmd_pending),
        .cmd_ack     (cmd_ack),
        .coll        (coll),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Behavioural model: 64 flat bytes, a set of dirty words, a pending flag, a sweep countdown.
    logic [7:0]  m_mem [64];
    logic [15:0] m_dirty;
    logic        m_cmd, m_coll, m_va, m_vb;
    logic [7:0]  m_qa;
    logic [31:0] m_qb;
    int          m_sweep_left = 0;
    int          m_sweep_ptr  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
        end
    endtask

    task automatic model_edge();
        int wa, la, wb;
        wa = int'(address_a) / 4;
        la = int'(address_a) % 4;
        wb = int'(address_b);
        if (reset) begin
            m_sweep_left = 16;
            m_sweep_ptr  = 0;
            m_qa = 8'h00; m_qb = 32'h0;
            m_va = 1'b0;  m_vb = 1'b0;
            m_coll = 1'b0; m_cmd = 1'b0; m_dirty = 16'h0;
        end else if (m_sweep_left > 0) begin
            for (int b = 0; b < 4; b++) m_mem[m_sweep_ptr*4 + b] = 8'h00;
            m_sweep_ptr++;
            m_sweep_left--;
            m_va = 1'b0; m_vb = 1'b0; m_coll = 1'b0;
        end else begin
            m_qa = m_mem[int'(address_a)];
            for (int l = 0; l < 4; l++) m_qb[8*l +: 8] = m_mem[wb*4 + l];
            m_va = oe_a;
            m_vb = rd_b;
            m_coll = wren_a && wren_b && (wa == wb) && be_b[la];
            if (rd_b) m_dirty[wb] = 1'b0;
            if (wren_a) m_dirty[wa] = 1'b1;
            if (wren_a && address_a == 6'h3F) m_cmd = 1'b1;
            else if (cmd_ack) m_cmd = 1'b0;
            if (wren_a) m_mem[int'(address_a)] = data_a;
            if (wren_b)
                for (int l = 0; l < 4; l++)
                    if (be_b[l]) m_mem[wb*4 + l] = data_b[8*l +: 8];
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; wren_a = 1'b0; oe_a = 1'b0; wren_b = 1'b0; rd_b = 1'b0; cmd_ack = 1'b0;
    endtask

    // One clock: update the model at the edge, compare all outputs just after it, return to idle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("busy",    32'(busy),        32'(m_sweep_left > 0));
        chk("valid_a", 32'(valid_a),     32'(m_va));
        chk("valid_b", 32'(valid_b),     32'(m_vb));
        chk("q_a",     32'(q_a),         32'(m_qa));
        chk("q_b",     q_b,              m_qb);
        chk("dirty",   32'(dirty),       32'(m_dirty));
        chk("cmd",     32'(cmd_pending), 32'(m_cmd));
        chk("coll",    32'(coll),        32'(m_coll));
        idle_inputs();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            n++;
            tick();
        end
    endtask

    int busy_len;

    initial begin
        idle_inputs();
        reset = 1'b1;
        address_a = '0; data_a = '0; address_b = '0; be_b = '0; data_b = '0;

        // Reset edge, then the sweep must hold busy for exactly 16 cycles.
        tick();
        chk("rst_q_a", 32'(q_a), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        count_busy(busy_len);
        chk("busy_len", 32'(busy_len), 32'd16);

        // Every word reads zero with valid_b one cycle after the strobe.
        for (int w = 0; w < 16; w++) begin
            rd_b = 1'b1; address_b = 4'(w);
            tick();
            chk("clr_word", q_b, 32'h0);
        end

        // Port A fills word 1, port B reads it back and clears dirty.
        for (int b = 0; b < 4; b++) begin
            wren_a = 1'b1; address_a = 6'(4 + b); data_a = 8'(8'h11 * (b + 1));
            tick();
        end
        chk("dirty1_set", 32'(dirty[1]), 32'h1);
        rd_b = 1'b1; address_b = 4'd1;
        tick();
        chk("word1", q_b, 32'h44332211);
        chk("dirty1_clr", 32'(dirty[1]), 32'h0);

        // Port B masked write; port A sees the enabled lane only.
        wren_b = 1'b1; address_b = 4'd2; data_b = 32'hAABBCCDD; be_b = 4'b0101;
        tick();
        oe_a = 1'b1; address_a = 6'd8;
        tick();
        chk("byte8", 32'(q_a), 32'hDD);
        oe_a = 1'b1; address_a = 6'd9;
        tick();
        chk("byte9", 32'(q_a), 32'h00);
        chk("dirty_b", 32'(dirty), 32'h0);

        // Same-byte collision: port B data wins, coll pulses once, dirty still set.
        wren_a = 1'b1; address_a = 6'd12; data_a = 8'h55;
        wren_b = 1'b1; address_b = 4'd3; data_b = 32'h000000AA; be_b = 4'b0001;
        tick();
        chk("coll_hi", 32'(coll), 32'h1);
        chk("dirty3", 32'(dirty[3]), 32'h1);
        oe_a = 1'b1; address_a = 6'd12;
        tick();
        chk("coll_lo", 32'(coll), 32'h0);
        chk("byte12", 32'(q_a), 32'hAA);

        // Command byte handshake.
        wren_a = 1'b1; address_a = 6'h3F; data_a = 8'h01;
        tick();
        chk("cmd_set", 32'(cmd_pending), 32'h1);
        wren_a = 1'b1; address_a = 6'h3F; data_a = 8'h02; cmd_ack = 1'b1;
        tick();
        chk("cmd_setwins", 32'(cmd_pending), 32'h1);
        cmd_ack = 1'b1;
        tick();
        chk("cmd_ack", 32'(cmd_pending), 32'h0);

        // Random traffic, biased towards collisions and the command byte.
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 249) == 0);
            address_b = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       address_a = {address_b, 2'($urandom_range(0, 3))};
                1:       address_a = 6'h3F;
                default: address_a = 6'($urandom);
            endcase
            wren_a  = 1'($urandom);
            data_a  = 8'($urandom);
            oe_a    = 1'($urandom);
            wren_b  = 1'($urandom);
            be_b    = 4'($urandom);
            data_b  = $urandom;
            rd_b    = 1'($urandom);
            cmd_ack = ($urandom_range(0, 3) == 0);
            tick();
        end
        for (int i = 0; i < 20; i++) tick();

        // Reset part-way through a sweep restarts it from word 0.
        wren_a = 1'b1; address_a = 6'd20; data_a = 8'h5A;
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) tick();
        chk("mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        count_busy(busy_len);
        chk("busy_len2", 32'(busy_len), 32'd16);
        for (int w = 0; w < 16; w++) begin
            rd_b = 1'b1; address_b = 4'(w);
            tick();
            chk("clr_word2", q_b, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
